// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default operand width.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_fa.sv
// Gate-level full-adder cell shared by the serial arithmetic blocks.
module fa (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic c
);

    logic ab_x;

    assign ab_x  = a ^ b;
    assign sum   = ab_x ^ c;
    assign carry = (a & b) | (c & ab_x);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell per clock, LSB first, with valid/ready handshakes.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fa_sum, fa_carry;

    fa u_fa (
        .sum   (fa_sum),
        .carry (fa_carry),
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                // Counter holds at its last value instead of wrapping on the final bit.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign sum       = out_valid ? sum_sh_q : '0;
    assign cout      = out_valid ? carry_q : 1'b0;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised self-checking bench for serial_add_ctrl at WIDTH=8 against an arithmetic reference.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        int unsigned total;
        total = int'(x) + int'(y) + int'(c);
        return total[W:0];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_sum"},       sum,       0);
        chk({tag, "_cout"},      cout,      0);
    endtask

    // Full transaction: request, latency count, optional stall in DONE, then accept.
    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input int hold);
        logic [W:0] exp;
        logic [W:0] held;
        int lat;
        exp = ref_add(av, bv, cv);
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                chk({tag, "_run_busy"},  busy, 1);
                chk({tag, "_run_rdy"},   in_ready, 0);
                chk({tag, "_run_sum0"},  sum, 0);
            end
        end while (!out_valid && lat < 40);
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_result"}, {cout, sum}, exp);
        held = {cout, sum};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_val"}, out_valid, 1);
            chk({tag, "_hold_res"}, {cout, sum}, held);
            chk({tag, "_hold_rdy"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_val"}, out_valid, 0);
        chk({tag, "_ack_rdy"}, in_ready, 1);
        chk({tag, "_ack_res"}, {cout, sum}, 0);
    endtask

    initial begin
        logic [W:0] exp_q[$];
        logic [W:0] exp;
        int sent;
        int got;
        int cyc;
        int last_acc;
        bit stale;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("v5a3c", 8'h5A, 8'h3C, 1'b0, 0);
        do_op("vff01", 8'hFF, 8'h01, 1'b0, 0);
        do_op("vffff", 8'hFF, 8'hFF, 1'b1, 5);
        for (int i = 0; i < 6; i++) begin
            do_op("rnd", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the third RUN cycle discards the operation.
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("midrst_stale", stale, 0);
        do_op("post_rst", 8'h01, 8'h01, 1'b0, 0);

        // Streaming: in_valid held high, out_ready tied high.
        out_ready = 1'b1;
        sent = 0; got = 0; cyc = 0; last_acc = -1;
        while (got < 1000 && cyc < 12000) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("stream_res", {cout, sum}, exp);
                end
                got++;
            end
            if (in_ready) begin
                if (sent < 1000) begin
                    if (last_acc >= 0) chk("stream_ii", cyc - last_acc, W + 2);
                    last_acc = cyc;
                    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                    in_valid = 1'b1;
                    exp_q.push_back(ref_add(a, b, cin));
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("stream_count", got, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
